vend_fsm_param: RTL and testbench

Parametrised coin-operated vending controller, successor to the fixed 2-state vending FSM. Accumulates credit from three coin denominations against a configurable price, issues a one-cycle vend pulse, and returns change or refunds as a serial coin stream with a valid/ready handshake. Sits between the coin acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/vend_chg_sel.sv | 27 ++
 rtl/vend_fsm_param.sv | 147 ++++++++++++++
 tb/tb_vend_fsm_param.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared coin codes, controller state encoding and the coin-value lookup
// for the vending controller family.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_3    = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    function automatic int coin_value(input logic [1:0] code, input int v1,
                                      input int v2, input int v3);
        case (code)
            COIN_1:  return v1;
            COIN_2:  return v2;
            COIN_3:  return v3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_chg_sel.sv
// Combinational largest-coin selector: picks the biggest denomination that
// does not exceed the given credit, and reports its code and value.
module vend_chg_sel
    import vend_pkg::*;
#(
    parameter int CW   = 8,
    parameter int VAL1 = 5,
    parameter int VAL2 = 10,
    parameter int VAL3 = 25
) (
    input  logic [CW-1:0] i_credit,
    output logic [1:0]    o_chg_coin,
    output logic [CW-1:0] o_chg_val
);

    always_comb begin
        o_chg_coin = COIN_NONE;
        if (i_credit >= CW'(VAL3))
            o_chg_coin = COIN_3;
        else if (i_credit >= CW'(VAL2))
            o_chg_coin = COIN_2;
        else if (i_credit >= CW'(VAL1))
            o_chg_coin = COIN_1;
        o_chg_val = CW'(coin_value(o_chg_coin, VAL1, VAL2, VAL3));
    end

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: credit accumulation, one-cycle vend pulse and
// serial change/refund with valid/ready. Stock counting via `define VEND_STOCK_EN.
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int CW         = 8,
    parameter int VAL1       = 5,
    parameter int VAL2       = 10,
    parameter int VAL3       = 25,
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 40,
    parameter int STOCK_INIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    i_coin_in,
    input  logic          i_cancel,
    input  logic          i_chg_ready,
`ifdef VEND_STOCK_EN
    input  logic          i_refill,
    output logic          o_sold_out,
`endif
    output logic [CW-1:0] o_credit,
    output logic          o_vend,
    output logic          o_coin_rej,
    output logic          o_chg_valid,
    output logic [1:0]    o_chg_coin,
    output logic          o_busy,
    output state_t        o_dbg_state
);

    localparam int CW1 = CW + 1;

    if (PRICE == 0 || (PRICE % VAL1) != 0 || (VAL2 % VAL1) != 0 || (VAL3 % VAL1) != 0 ||
        MAX_CREDIT < PRICE || MAX_CREDIT >= (1 << CW) || STOCK_INIT < 1) begin : g_bad_cfg
        $error("vend_fsm_param: inconsistent parameter set");
    end

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_credit, w_credit_nxt;
    logic [CW-1:0] r_chg_val, w_sel_val;
    logic [1:0]    r_chg_coin, w_sel_coin;
    logic          r_vend, r_coin_rej, r_chg_valid, r_busy;
    logic          w_rej_nxt;
    logic [CW:0]   w_coin_val, w_sum;
    logic          w_coin_fits, w_cancel, w_sold_out;

`ifdef VEND_STOCK_EN
    localparam int SW = $clog2(STOCK_INIT + 1);
    logic [SW-1:0] r_stock;

    // refill takes priority over the decrement on the VEND exit edge
    always_ff @(posedge clk) begin
        if (rst || i_refill)
            r_stock <= SW'(STOCK_INIT);
        else if (r_state == VEND && r_stock != '0)
            r_stock <= r_stock - SW'(1);
    end

    assign w_sold_out = (r_stock == '0);
    assign o_sold_out = w_sold_out;
`else
    assign w_sold_out = 1'b0;
`endif

    // one bit of headroom so an oversized coin cannot wrap below the ceiling
    assign w_coin_val  = CW1'(coin_value(i_coin_in, VAL1, VAL2, VAL3));
    assign w_sum       = {1'b0, r_credit} + w_coin_val;
    assign w_coin_fits = (w_sum <= CW1'(MAX_CREDIT));
    assign w_cancel    = i_cancel && (r_credit != '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_rej_nxt    = 1'b0;
        case (r_state)
            IDLE, COLLECT: begin
                if (w_cancel || (w_sold_out && r_credit != '0)) begin
                    w_state_nxt = CHANGE;
                    w_rej_nxt   = (i_coin_in != COIN_NONE);
                end else if (i_coin_in != COIN_NONE) begin
                    if (w_coin_fits && !w_sold_out) begin
                        w_credit_nxt = w_sum[CW-1:0];
                        w_state_nxt  = (w_sum >= CW1'(PRICE)) ? VEND : COLLECT;
                    end else begin
                        w_rej_nxt = 1'b1;
                    end
                end
            end
            VEND: begin
                w_rej_nxt    = (i_coin_in != COIN_NONE);
                w_credit_nxt = r_credit - CW'(PRICE);
                w_state_nxt  = (w_credit_nxt != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                w_rej_nxt = (i_coin_in != COIN_NONE);
                if (r_chg_valid && i_chg_ready)
                    w_credit_nxt = r_credit - r_chg_val;
                if (w_credit_nxt == '0)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    vend_chg_sel #(
        .CW   (CW),
        .VAL1 (VAL1),
        .VAL2 (VAL2),
        .VAL3 (VAL3)
    ) u_chg_sel (
        .i_credit   (w_credit_nxt),
        .o_chg_coin (w_sel_coin),
        .o_chg_val  (w_sel_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_credit    <= '0;
            r_vend      <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_chg_valid <= 1'b0;
            r_chg_coin  <= COIN_NONE;
            r_chg_val   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_credit    <= w_credit_nxt;
            r_vend      <= (w_state_nxt == VEND);
            r_coin_rej  <= w_rej_nxt;
            r_chg_valid <= (w_state_nxt == CHANGE);
            r_chg_coin  <= (w_state_nxt == CHANGE) ? w_sel_coin : COIN_NONE;
            r_chg_val   <= (w_state_nxt == CHANGE) ? w_sel_val : '0;
            r_busy      <= (w_state_nxt == VEND) || (w_state_nxt == CHANGE);
        end
    end

    assign o_credit    = r_credit;
    assign o_vend      = r_vend;
    assign o_coin_rej  = r_coin_rej;
    assign o_chg_valid = r_chg_valid;
    assign o_chg_coin  = r_chg_coin;
    assign o_busy      = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed bench for vend_fsm_param: default-price unit, a PRICE=40 unit and,
// with VEND_STOCK_EN, a STOCK_INIT=1 unit.
module tb_vend_fsm_param;
    import vend_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default unit (PRICE 15, MAX 40)
    logic [1:0] coin;
    logic       cancel, chg_ready;
    logic [7:0] credit;
    logic       vend, rej, cv, busy;
    logic [1:0] cc;
    state_t     dbg;

    // PRICE 40 unit
    logic [1:0] coin_b;
    logic [7:0] credit_b;
    logic       vend_b, rej_b, cv_b, busy_b;
    logic [1:0] cc_b;
    state_t     dbg_b;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] exp_q[$];

`ifdef VEND_STOCK_EN
    logic       refill_a = 1'b0;
    logic       sold_a, sold_b;
    logic [1:0] coin_c;
    logic       refill_c, chg_ready_c;
    logic [7:0] credit_c;
    logic       vend_c, rej_c, cv_c, busy_c, sold_c;
    logic [1:0] cc_c;
    state_t     dbg_c;
`endif

    vend_fsm_param u_dut (
        .clk(clk), .rst(rst), .i_coin_in(coin), .i_cancel(cancel), .i_chg_ready(chg_ready),
`ifdef VEND_STOCK_EN
        .i_refill(refill_a), .o_sold_out(sold_a),
`endif
        .o_credit(credit), .o_vend(vend), .o_coin_rej(rej), .o_chg_valid(cv),
        .o_chg_coin(cc), .o_busy(busy), .o_dbg_state(dbg)
    );

    vend_fsm_param #(.PRICE(40)) u_dut_p40 (
        .clk(clk), .rst(rst), .i_coin_in(coin_b), .i_cancel(1'b0), .i_chg_ready(1'b1),
`ifdef VEND_STOCK_EN
        .i_refill(1'b0), .o_sold_out(sold_b),
`endif
        .o_credit(credit_b), .o_vend(vend_b), .o_coin_rej(rej_b), .o_chg_valid(cv_b),
        .o_chg_coin(cc_b), .o_busy(busy_b), .o_dbg_state(dbg_b)
    );

`ifdef VEND_STOCK_EN
    vend_fsm_param #(.STOCK_INIT(1)) u_dut_stk (
        .clk(clk), .rst(rst), .i_coin_in(coin_c), .i_cancel(1'b0), .i_chg_ready(chg_ready_c),
        .i_refill(refill_c), .o_sold_out(sold_c),
        .o_credit(credit_c), .o_vend(vend_c), .o_coin_rej(rej_c), .o_chg_valid(cv_c),
        .o_chg_coin(cc_c), .o_busy(busy_c), .o_dbg_state(dbg_c)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; coin = 2'b00; cancel = 1'b0; chg_ready = 1'b0; coin_b = 2'b00;
`ifdef VEND_STOCK_EN
        coin_c = 2'b00; refill_c = 1'b0; chg_ready_c = 1'b1;
`endif
        tick(); tick();
        chk("rst_credit", credit, 0);
        chk("rst_vend", vend, 0);
        chk("rst_rej", rej, 0);
        chk("rst_chg_valid", cv, 0);
        chk("rst_chg_coin", cc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg, IDLE);
        rst = 1'b0;

        // exact payment 5+5+5
        coin = 2'b01;
        tick(); chk("exact_c1", credit, 5);  chk("exact_vend1", vend, 0);
        tick(); chk("exact_c2", credit, 10);
        tick(); chk("exact_c3", credit, 15); chk("exact_vend", vend, 1);
        chk("exact_busy", busy, 1); chk("exact_state", dbg, VEND);
        coin = 2'b00;
        tick(); chk("exact_after_credit", credit, 0); chk("exact_after_vend", vend, 0);
        chk("exact_no_chg", cv, 0); chk("exact_idle_busy", busy, 0);

        // overpay 25 -> change 10
        chg_ready = 1'b1; coin = 2'b11;
        tick(); chk("over_vend", vend, 1); chk("over_credit", credit, 25);
        coin = 2'b00;
        tick(); chk("over_cv", cv, 1); chk("over_cc", cc, 2'b10); chk("over_rem", credit, 10);
        chk("over_vend_drop", vend, 0);
        tick(); chk("over_done", credit, 0); chk("over_cv_drop", cv, 0); chk("over_state", dbg, IDLE);

        // cancel with stalled hopper
        chg_ready = 1'b0; coin = 2'b10;
        tick(); chk("cancel_credit", credit, 10);
        coin = 2'b00; cancel = 1'b1;
        tick(); cancel = 1'b0;
        chk("cancel_cv", cv, 1); chk("cancel_cc", cc, 2'b10); chk("cancel_credit_hold", credit, 10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_cv", cv, 1); chk("stall_cc", cc, 2'b10);
            chk("stall_credit", credit, 10); chk("stall_vend", vend, 0);
        end
        chg_ready = 1'b1;
        tick(); chk("cancel_done", credit, 0); chk("cancel_cv_drop", cv, 0); chk("cancel_novend", vend, 0);

        // 10 + 25 = 35 -> change 20 as two 10s
        coin = 2'b10; tick();
        coin = 2'b11; tick();
        chk("ceil_credit", credit, 35); chk("ceil_vend", vend, 1);
        coin = 2'b00;
        exp_q.push_back(2'b10); exp_q.push_back(2'b10);
        tick(); chk("ceil_rem", credit, 20);
        for (int i = 0; i < 8 && cv; i++) begin
            if (exp_q.size() == 0) chk("ceil_extra_coin", cc, 0);
            else chk("ceil_chg_coin", cc, exp_q.pop_front());
            tick();
        end
        chk("ceil_q_left", exp_q.size(), 0);
        chk("ceil_done", credit, 0); chk("ceil_cv_drop", cv, 0);

        // reset while in CHANGE
        chg_ready = 1'b0; coin = 2'b10; tick();
        coin = 2'b00; cancel = 1'b1; tick(); cancel = 1'b0;
        chk("rstchg_cv", cv, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstchg_credit", credit, 0); chk("rstchg_cv", cv, 0); chk("rstchg_busy", busy, 0);

        // coin together with cancel, then coins while busy
        coin = 2'b10; tick(); chk("sim_credit", credit, 10);
        coin = 2'b01; cancel = 1'b1; tick(); cancel = 1'b0;
        chk("sim_rej", rej, 1); chk("sim_cv", cv, 1); chk("sim_credit_hold", credit, 10);
        coin = 2'b11; tick();
        chk("chg_coin_rej", rej, 1); chk("chg_coin_credit", credit, 10); chk("chg_coin_cv", cv, 1);
        coin = 2'b00; chg_ready = 1'b1; tick();
        chk("sim_rej_drop", rej, 0); chk("sim_done", credit, 0);
        coin = 2'b11; tick(); chk("vcoin_vend", vend, 1); chk("vcoin_credit", credit, 25);
        coin = 2'b01; tick();
        chk("vend_coin_rej", rej, 1); chk("vend_coin_credit", credit, 10); chk("vend_coin_cc", cc, 2'b10);
        coin = 2'b00; tick(); chk("vcoin_done", credit, 0); chk("vcoin_cv_drop", cv, 0);

        // PRICE=40: 25, 10, then 10 exceeds the 40 ceiling
        coin_b = 2'b11; tick(); chk("p40_c1", credit_b, 25); chk("p40_novend", vend_b, 0);
        coin_b = 2'b10; tick(); chk("p40_c2", credit_b, 35);
        tick(); chk("p40_rej", rej_b, 1); chk("p40_hold", credit_b, 35);
        coin_b = 2'b01; tick(); chk("p40_full", credit_b, 40); chk("p40_vend", vend_b, 1); chk("p40_rej_drop", rej_b, 0);
        coin_b = 2'b00; tick(); chk("p40_done", credit_b, 0); chk("p40_nochg", cv_b, 0);

`ifdef VEND_STOCK_EN
        // STOCK_INIT=1: sell once, then sold out until refill
        chk("stk_init", sold_c, 0);
        coin_c = 2'b11; tick(); chk("stk_vend", vend_c, 1);
        coin_c = 2'b00; tick(); chk("stk_sold", sold_c, 1); chk("stk_rem", credit_c, 10);
        tick(); chk("stk_drain", credit_c, 0);
        coin_c = 2'b01; tick(); chk("stk_rej", rej_c, 1); chk("stk_credit", credit_c, 0);
        coin_c = 2'b00; refill_c = 1'b1; tick(); refill_c = 1'b0;
        chk("stk_refill", sold_c, 0);
        coin_c = 2'b01; tick(); chk("stk_accept", credit_c, 5); chk("stk_rej_drop", rej_c, 0);
        coin_c = 2'b00;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
